// File: rtl/dma_isr_arbiter_credit_if.sv
// Request/forward/completion bundle for the ISR DMA arbiter.
// The slave modport is the arbiter's view; the master modport is the view of
// the request sources, downstream DMA engines and completion consumers.
interface dma_isr_arbiter_credit_if #(
  parameter int N_CH       = 4,
  parameter int PADDR_BITS = 64,
  parameter int LEN_BITS   = 28,
  parameter int PID_BITS   = 6,
  parameter int DEST_BITS  = 4,
  parameter int CNT_W      = 3
);
  // per-channel requests, channel i at slice i
  logic [N_CH-1:0]            s_valid;
  logic [N_CH-1:0]            s_ready;
  logic [N_CH*PADDR_BITS-1:0] s_paddr_host;
  logic [N_CH*PADDR_BITS-1:0] s_paddr_card;
  logic [N_CH*LEN_BITS-1:0]   s_len;
  logic [N_CH-1:0]            s_ctl;
  logic [N_CH*PID_BITS-1:0]   s_pid;
  logic [N_CH*DEST_BITS-1:0]  s_dest;
  logic [N_CH-1:0]            s_stream;
  logic [N_CH-1:0]            s_host;
  // forked request towards host (XDMA) and card (CDMA)
  logic                       m_host_valid;
  logic                       m_card_valid;
  logic                       m_host_ready;
  logic                       m_card_ready;
  logic [PADDR_BITS-1:0]      m_host_paddr;
  logic [PADDR_BITS-1:0]      m_card_paddr;
  logic [LEN_BITS-1:0]        m_len;
  logic                       m_ctl;
  // completions and status
  logic                       host_done;
  logic                       card_done;
  logic [N_CH-1:0]            rsp_done;
  logic [PID_BITS-1:0]        rsp_pid;
  logic [DEST_BITS-1:0]       rsp_dest;
  logic                       rsp_stream;
  logic                       rsp_host;
  logic [N_CH*CNT_W-1:0]      credit_cnt;
  logic                       err_spurious;

  modport slave (
    input  s_valid, s_paddr_host, s_paddr_card, s_len, s_ctl, s_pid, s_dest,
           s_stream, s_host, m_host_ready, m_card_ready, host_done, card_done,
    output s_ready, m_host_valid, m_card_valid, m_host_paddr, m_card_paddr,
           m_len, m_ctl, rsp_done, rsp_pid, rsp_dest, rsp_stream, rsp_host,
           credit_cnt, err_spurious
  );

  modport master (
    output s_valid, s_paddr_host, s_paddr_card, s_len, s_ctl, s_pid, s_dest,
           s_stream, s_host, m_host_ready, m_card_ready, host_done, card_done,
    input  s_ready, m_host_valid, m_card_valid, m_host_paddr, m_card_paddr,
           m_len, m_ctl, rsp_done, rsp_pid, rsp_dest, rsp_stream, rsp_host,
           credit_cnt, err_spurious
  );
endinterface

// File: rtl/dma_isr_arbiter_credit.sv
// Round-robin arbiter for ISR DMA requests from N_CH region FSMs.
// A granted request is forked to host and card ports in the same cycle.
// Requests flagged ctl expect an in-order completion; their tags sit in a
// small FIFO and each channel may hold at most CH_CREDITS of them.
module dma_isr_arbiter_credit #(
  parameter int N_CH          = 4,
  parameter int N_OUTSTANDING = 8,
  parameter int CH_CREDITS    = 4,
  parameter int PADDR_BITS    = 64,
  parameter int LEN_BITS      = 28,
  parameter int PID_BITS      = 6,
  parameter int DEST_BITS     = 4,
  parameter int DONE_SEL      = 0
)(
  input logic                     aclk,
  input logic                     aresetn,
  dma_isr_arbiter_credit_if.slave bus
);
  localparam int CH_W  = (N_CH > 1) ? $clog2(N_CH) : 1;
  localparam int CNT_W = $clog2(CH_CREDITS + 1);
  localparam int PTR_W = (N_OUTSTANDING > 1) ? $clog2(N_OUTSTANDING) : 1;

  typedef struct packed {
    logic                 host;
    logic                 stream;
    logic [DEST_BITS-1:0] dest;
    logic [CH_W-1:0]      ch;
    logic [PID_BITS-1:0]  pid;
  } ent_t;

  logic [CH_W-1:0]      r_last_grant;
  logic [CNT_W-1:0]     r_credit [N_CH];
  ent_t                 r_fifo [N_OUTSTANDING];
  logic [PTR_W-1:0]     r_wptr;
  logic [PTR_W-1:0]     r_rptr;
  logic [PTR_W:0]       r_count;
  logic [N_CH-1:0]      r_rsp_done;
  logic [PID_BITS-1:0]  r_rsp_pid;
  logic [DEST_BITS-1:0] r_rsp_dest;
  logic                 r_rsp_stream;
  logic                 r_rsp_host;
  logic                 r_err;

  logic [N_CH-1:0]      w_elig;
  logic [CH_W-1:0]      w_grant;
  logic                 w_grant_any;
  logic                 w_issue;
  logic                 w_push;
  logic                 w_pop;
  logic                 w_done;
  logic                 w_empty;
  logic                 w_full;
  logic                 w_sel_ctl;
  logic [PID_BITS-1:0]  w_sel_pid;
  logic [DEST_BITS-1:0] w_sel_dest;
  logic                 w_sel_stream;
  logic                 w_sel_host;
  ent_t                 w_head;

  // Full is taken from the registered count, so a same-cycle pop never frees a slot early.
  assign w_empty = (r_count == {(PTR_W+1){1'b0}});
  assign w_full  = (r_count == (PTR_W+1)'(N_OUTSTANDING));
  assign w_done  = (DONE_SEL != 0) ? bus.host_done : bus.card_done;
  assign w_pop   = w_done & ~w_empty;
  assign w_issue = w_grant_any & bus.m_host_ready & bus.m_card_ready;
  assign w_push  = w_issue & w_sel_ctl;
  assign w_head  = r_fifo[r_rptr];

  // Channel is eligible if valid and, for ctl requests, it has credit and the queue has room.
  always_comb begin
    w_elig = {N_CH{1'b0}};
    for (int i = 0; i < N_CH; i++) begin
      w_elig[i] = bus.s_valid[i] &
                  (~bus.s_ctl[i] | ((r_credit[i] < CNT_W'(CH_CREDITS)) & ~w_full));
    end
  end

  // Search eligible channels starting just after the last grant, wrapping around.
  always_comb begin : grant_search
    int              v_idx;
    logic [CH_W-1:0] v_cand;
    logic            v_hit;
    w_grant_any = 1'b0;
    w_grant     = {CH_W{1'b0}};
    v_idx       = 0;
    v_cand      = {CH_W{1'b0}};
    v_hit       = 1'b0;
    for (int k = 1; k <= N_CH; k++) begin
      v_idx       = (int'(r_last_grant) + k) % N_CH;
      v_cand      = CH_W'(v_idx);
      v_hit       = ~w_grant_any & w_elig[v_cand];
      w_grant     = v_hit ? v_cand : w_grant;
      w_grant_any = w_grant_any | v_hit;
    end
  end

  // Mux the granted channel's payload onto the forked ports and raise its s_ready.
  always_comb begin
    bus.m_host_paddr = {PADDR_BITS{1'b0}};
    bus.m_card_paddr = {PADDR_BITS{1'b0}};
    bus.m_len        = {LEN_BITS{1'b0}};
    bus.s_ready      = {N_CH{1'b0}};
    w_sel_ctl        = 1'b0;
    w_sel_pid        = {PID_BITS{1'b0}};
    w_sel_dest       = {DEST_BITS{1'b0}};
    w_sel_stream     = 1'b0;
    w_sel_host       = 1'b0;
    for (int i = 0; i < N_CH; i++) begin
      bus.s_ready[i]   = w_issue & (w_grant == CH_W'(i));
      bus.m_host_paddr = (w_grant == CH_W'(i)) ? bus.s_paddr_host[i*PADDR_BITS +: PADDR_BITS] : bus.m_host_paddr;
      bus.m_card_paddr = (w_grant == CH_W'(i)) ? bus.s_paddr_card[i*PADDR_BITS +: PADDR_BITS] : bus.m_card_paddr;
      bus.m_len        = (w_grant == CH_W'(i)) ? bus.s_len[i*LEN_BITS +: LEN_BITS] : bus.m_len;
      w_sel_ctl        = (w_grant == CH_W'(i)) ? bus.s_ctl[i] : w_sel_ctl;
      w_sel_pid        = (w_grant == CH_W'(i)) ? bus.s_pid[i*PID_BITS +: PID_BITS] : w_sel_pid;
      w_sel_dest       = (w_grant == CH_W'(i)) ? bus.s_dest[i*DEST_BITS +: DEST_BITS] : w_sel_dest;
      w_sel_stream     = (w_grant == CH_W'(i)) ? bus.s_stream[i] : w_sel_stream;
      w_sel_host       = (w_grant == CH_W'(i)) ? bus.s_host[i] : w_sel_host;
    end
  end

  assign bus.m_host_valid = w_issue;
  assign bus.m_card_valid = w_issue;
  assign bus.m_ctl        = w_sel_ctl;
  assign bus.rsp_done     = r_rsp_done;
  assign bus.rsp_pid      = r_rsp_pid;
  assign bus.rsp_dest     = r_rsp_dest;
  assign bus.rsp_stream   = r_rsp_stream;
  assign bus.rsp_host     = r_rsp_host;
  assign bus.err_spurious = r_err;

  // Flatten per-channel credit counters onto the status bus.
  always_comb begin
    bus.credit_cnt = {(N_CH*CNT_W){1'b0}};
    for (int i = 0; i < N_CH; i++) begin
      bus.credit_cnt[i*CNT_W +: CNT_W] = r_credit[i];
    end
  end

  // Completion tag storage; contents need no reset since count gates every read.
  always_ff @(posedge aclk) begin
    if (w_push) begin
      r_fifo[r_wptr] <= {w_sel_host, w_sel_stream, w_sel_dest, w_grant, w_sel_pid};
    end else begin
      r_fifo[r_wptr] <= r_fifo[r_wptr];
    end
  end

  // Round-robin pointer, queue pointers, credits, registered responses and spurious flag.
  always_ff @(posedge aclk) begin
    if (!aresetn) begin
      r_last_grant <= CH_W'(N_CH - 1);
      r_wptr       <= {PTR_W{1'b0}};
      r_rptr       <= {PTR_W{1'b0}};
      r_count      <= {(PTR_W+1){1'b0}};
      r_rsp_done   <= {N_CH{1'b0}};
      r_rsp_pid    <= {PID_BITS{1'b0}};
      r_rsp_dest   <= {DEST_BITS{1'b0}};
      r_rsp_stream <= 1'b0;
      r_rsp_host   <= 1'b0;
      r_err        <= 1'b0;
      for (int i = 0; i < N_CH; i++) r_credit[i] <= {CNT_W{1'b0}};
    end else begin
      if (w_issue) r_last_grant <= w_grant;
      if (w_push) r_wptr <= (r_wptr == PTR_W'(N_OUTSTANDING - 1)) ? {PTR_W{1'b0}} : r_wptr + PTR_W'(1'b1);
      if (w_pop)  r_rptr <= (r_rptr == PTR_W'(N_OUTSTANDING - 1)) ? {PTR_W{1'b0}} : r_rptr + PTR_W'(1'b1);
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + (PTR_W+1)'(1'b1);
        2'b01:   r_count <= r_count - (PTR_W+1)'(1'b1);
        default: r_count <= r_count;
      endcase
      // an issue and a completion on the same channel cancel out
      for (int i = 0; i < N_CH; i++) begin
        case ({w_push && (w_grant == CH_W'(i)), w_pop && (w_head.ch == CH_W'(i))})
          2'b10:   r_credit[i] <= r_credit[i] + CNT_W'(1'b1);
          2'b01:   r_credit[i] <= r_credit[i] - CNT_W'(1'b1);
          default: r_credit[i] <= r_credit[i];
        endcase
        r_rsp_done[i] <= w_pop && (w_head.ch == CH_W'(i));
      end
      if (w_pop) begin
        r_rsp_pid    <= w_head.pid;
        r_rsp_dest   <= w_head.dest;
        r_rsp_stream <= w_head.stream;
        r_rsp_host   <= w_head.host;
      end
      if (w_done && w_empty) r_err <= 1'b1;
    end
  end
endmodule

// File: tb/tb_dma_isr_arbiter_credit.sv
// Self-checking bench for dma_isr_arbiter_credit: N_CH=4, queue depth 4,
// 2 credits per channel. A second instance checks the host-done selection.
module tb_dma_isr_arbiter_credit;
  logic aclk = 1'b0;
  logic aresetn = 1'b0;
  int   n_checks = 0;
  int   n_errors = 0;

  typedef struct {
    int         ch;
    logic [5:0] pid;
    logic [3:0] dest;
    logic       stream;
    logic       host;
  } exp_t;
  exp_t sb[$];

  dma_isr_arbiter_credit_if #(.N_CH(4), .PADDR_BITS(64), .LEN_BITS(28), .PID_BITS(6),
                              .DEST_BITS(4), .CNT_W(2)) bus0 ();
  dma_isr_arbiter_credit_if #(.N_CH(4), .PADDR_BITS(64), .LEN_BITS(28), .PID_BITS(6),
                              .DEST_BITS(4), .CNT_W(2)) bus1 ();

  dma_isr_arbiter_credit #(.N_CH(4), .N_OUTSTANDING(4), .CH_CREDITS(2), .PADDR_BITS(64),
                           .LEN_BITS(28), .PID_BITS(6), .DEST_BITS(4), .DONE_SEL(0))
    dut (.aclk(aclk), .aresetn(aresetn), .bus(bus0));

  dma_isr_arbiter_credit #(.N_CH(4), .N_OUTSTANDING(4), .CH_CREDITS(2), .PADDR_BITS(64),
                           .LEN_BITS(28), .PID_BITS(6), .DEST_BITS(4), .DONE_SEL(1))
    dut_h (.aclk(aclk), .aresetn(aresetn), .bus(bus1));

  always #5 aclk = ~aclk;

  function automatic logic [63:0] paddr_h(input int ch);
    return 64'hA5A5_0000_0000_1000 + 64'(ch);
  endfunction
  function automatic logic [63:0] paddr_c(input int ch);
    return 64'hC3C3_0000_0000_2000 + 64'(ch);
  endfunction
  function automatic logic [27:0] plen(input int ch, input logic [5:0] pid);
    return 28'(ch * 256) + 28'(pid);
  endfunction
  function automatic exp_t mk(input int ch, input logic [5:0] pid);
    exp_t e;
    e.ch = ch; e.pid = pid; e.dest = 4'(ch) ^ pid[3:0]; e.stream = pid[0]; e.host = pid[1];
    return e;
  endfunction
  function automatic logic [1:0] crd0(input int ch);
    return bus0.credit_cnt[2*ch +: 2];
  endfunction

  task automatic tick();
    @(posedge aclk);
    #1;
  endtask

  task automatic clr0();
    bus0.s_valid = 4'b0000; bus0.s_ctl = 4'b0000;
    bus0.card_done = 1'b0; bus0.host_done = 1'b0;
  endtask

  task automatic set_req(input int ch, input logic ctl, input logic [5:0] pid);
    exp_t e;
    e = mk(ch, pid);
    bus0.s_valid[ch] = 1'b1;  bus0.s_ctl[ch] = ctl;
    bus0.s_pid[ch*6 +: 6] = pid;  bus0.s_dest[ch*4 +: 4] = e.dest;
    bus0.s_stream[ch] = e.stream;  bus0.s_host[ch] = e.host;
    bus0.s_paddr_host[ch*64 +: 64] = paddr_h(ch);
    bus0.s_paddr_card[ch*64 +: 64] = paddr_c(ch);
    bus0.s_len[ch*28 +: 28] = plen(ch, pid);
  endtask

  // one card_done strobe, then compare the registered response with the scoreboard head
  task automatic do_completion(input string tag);
    exp_t e;
    bus0.card_done = 1'b1;
    tick();
    bus0.card_done = 1'b0;
    @(negedge aclk);
    n_checks++;
    if (sb.size() == 0) begin
      n_errors++; $display("FAIL %s: scoreboard empty, rsp_done=%b", tag, bus0.rsp_done);
    end else begin
      e = sb.pop_front();
      if (bus0.rsp_done !== (4'b0001 << e.ch)) begin
        n_errors++; $display("FAIL %s rsp_done: got %b want %b", tag, bus0.rsp_done, 4'b0001 << e.ch);
      end
      n_checks++;
      if ({bus0.rsp_pid, bus0.rsp_dest, bus0.rsp_stream, bus0.rsp_host} !== {e.pid, e.dest, e.stream, e.host}) begin
        n_errors++; $display("FAIL %s rsp_meta: got pid=%0d dest=%h s=%b h=%b want pid=%0d dest=%h s=%b h=%b",
                             tag, bus0.rsp_pid, bus0.rsp_dest, bus0.rsp_stream, bus0.rsp_host,
                             e.pid, e.dest, e.stream, e.host);
      end
    end
    tick();
  endtask

  task automatic test_reset();
    aresetn = 1'b0;
    set_req(2, 1'b0, 6'd3);
    repeat (2) @(posedge aclk);
    #1;
    @(negedge aclk);
    n_checks++;
    if (bus0.s_ready !== 4'b0100) begin n_errors++; $display("FAIL reset_sready: got %b want 0100", bus0.s_ready); end
    n_checks++;
    if ({bus0.credit_cnt, bus0.err_spurious, bus0.rsp_done} !== 13'd0) begin
      n_errors++; $display("FAIL reset_state: credit=%h err=%b rsp=%b want zeros", bus0.credit_cnt, bus0.err_spurious, bus0.rsp_done);
    end
    clr0();
    #1;
    n_checks++;
    if ({bus0.m_host_valid, bus0.m_card_valid, bus0.s_ready} !== 6'd0) begin
      n_errors++; $display("FAIL reset_idle: got hv=%b cv=%b sr=%b want 0", bus0.m_host_valid, bus0.m_card_valid, bus0.s_ready);
    end
    tick();
    aresetn = 1'b1;
  endtask

  task automatic test_fairness();
    int seq2[3] = '{0, 2, 3};
    int g;
    for (int c = 0; c < 4; c++) set_req(c, 1'b0, 6'(c + 1));
    for (int i = 0; i < 14; i++) begin
      if (i == 8) bus0.s_valid[1] = 1'b0;
      g = (i < 8) ? (i % 4) : seq2[(i - 8) % 3];
      @(negedge aclk);
      n_checks++;
      if (bus0.s_ready !== (4'b0001 << g)) begin
        n_errors++; $display("FAIL fair_grant[%0d]: got %b want %b", i, bus0.s_ready, 4'b0001 << g);
      end
      n_checks++;
      if ({bus0.m_host_valid, bus0.m_card_valid, bus0.m_ctl, bus0.m_host_paddr, bus0.m_card_paddr, bus0.m_len}
          !== {1'b1, 1'b1, 1'b0, paddr_h(g), paddr_c(g), plen(g, 6'(g + 1))}) begin
        n_errors++; $display("FAIL fair_payload[%0d]: got hv=%b cv=%b ha=%h ca=%h len=%h want ch %0d",
                             i, bus0.m_host_valid, bus0.m_card_valid, bus0.m_host_paddr, bus0.m_card_paddr, bus0.m_len, g);
      end
      tick();
    end
    clr0();
    tick();
  endtask

  task automatic test_backpressure();
    set_req(0, 1'b0, 6'd4);
    bus0.m_card_ready = 1'b0;
    @(negedge aclk);
    n_checks++;
    if ({bus0.m_host_valid, bus0.m_card_valid, bus0.s_ready} !== 6'd0) begin
      n_errors++; $display("FAIL bp_stall: got hv=%b cv=%b sr=%b want 0", bus0.m_host_valid, bus0.m_card_valid, bus0.s_ready);
    end
    tick();
    bus0.m_card_ready = 1'b1;
    @(negedge aclk);
    n_checks++;
    if ({bus0.m_host_valid, bus0.m_card_valid, bus0.s_ready, bus0.m_card_paddr} !== {2'b11, 4'b0001, paddr_c(0)}) begin
      n_errors++; $display("FAIL bp_release: got hv=%b cv=%b sr=%b ca=%h want 1 1 0001", bus0.m_host_valid, bus0.m_card_valid, bus0.s_ready, bus0.m_card_paddr);
    end
    tick();
    clr0();
  endtask

  task automatic test_credits();
    exp_t e;
    int   acc = 0;
    for (int k = 0; k < 4; k++) begin
      set_req(2, 1'b1, 6'(10 + k));
      @(negedge aclk);
      n_checks++;
      if (bus0.s_ready !== ((acc < 2) ? 4'b0100 : 4'b0000)) begin
        n_errors++; $display("FAIL credit_accept[%0d]: got %b want %b", k, bus0.s_ready, (acc < 2) ? 4'b0100 : 4'b0000);
      end
      if (acc < 2) begin sb.push_back(mk(2, 6'(10 + k))); acc++; end
      tick();
    end
    set_req(2, 1'b1, 6'd20);
    set_req(0, 1'b0, 6'd21);
    @(negedge aclk);
    n_checks++;
    if ({crd0(2), bus0.s_ready} !== {2'd2, 4'b0001}) begin
      n_errors++; $display("FAIL credit_limit: got credit=%0d sr=%b want 2 0001", crd0(2), bus0.s_ready);
    end
    tick();
    bus0.s_valid[0] = 1'b0;
    bus0.card_done = 1'b1;
    @(negedge aclk);
    n_checks++;
    if (bus0.s_ready !== 4'b0000) begin n_errors++; $display("FAIL credit_blocked: got %b want 0000", bus0.s_ready); end
    tick();
    bus0.card_done = 1'b0;
    @(negedge aclk);
    e = sb.pop_front();
    n_checks++;
    if ({bus0.rsp_done, bus0.rsp_pid, crd0(2), bus0.s_ready} !== {4'b0100, e.pid, 2'd1, 4'b0100}) begin
      n_errors++; $display("FAIL credit_return: got rsp=%b pid=%0d credit=%0d sr=%b want 0100 %0d 1 0100",
                           bus0.rsp_done, bus0.rsp_pid, crd0(2), bus0.s_ready, e.pid);
    end
    sb.push_back(mk(2, 6'd20));
    tick();
    clr0();
    @(negedge aclk);
    n_checks++;
    if ({bus0.rsp_done, bus0.rsp_pid, crd0(2)} !== {4'b0000, 6'd10, 2'd2}) begin
      n_errors++; $display("FAIL credit_pulse_hold: got rsp=%b pid=%0d credit=%0d want 0000 10 2", bus0.rsp_done, bus0.rsp_pid, crd0(2));
    end
    tick();
    do_completion("credit_drain0");
    do_completion("credit_drain1");
    @(negedge aclk);
    n_checks++;
    if (bus0.credit_cnt !== 8'h00) begin n_errors++; $display("FAIL credit_zero: got %h want 00", bus0.credit_cnt); end
    tick();
  endtask

  task automatic test_ordering();
    int         chs[3]  = '{3, 1, 3};
    logic [5:0] pids[3] = '{6'd5, 6'd9, 6'd7};
    for (int k = 0; k < 3; k++) begin
      set_req(chs[k], 1'b1, pids[k]);
      @(negedge aclk);
      n_checks++;
      if ({bus0.s_ready, bus0.m_ctl} !== {4'b0001 << chs[k], 1'b1}) begin
        n_errors++; $display("FAIL order_issue[%0d]: got sr=%b ctl=%b want %b 1", k, bus0.s_ready, bus0.m_ctl, 4'b0001 << chs[k]);
      end
      sb.push_back(mk(chs[k], pids[k]));
      tick();
      clr0();
    end
    do_completion("order0");
    do_completion("order1");
    do_completion("order2");
    @(negedge aclk);
    n_checks++;
    if ({bus0.rsp_done, bus0.rsp_pid} !== {4'b0000, 6'd7}) begin
      n_errors++; $display("FAIL order_hold: got rsp=%b pid=%0d want 0000 7", bus0.rsp_done, bus0.rsp_pid);
    end
    tick();
  endtask

  task automatic test_full_and_simul();
    exp_t       e;
    int         chs[4]  = '{0, 1, 0, 2};
    logic [5:0] pids[4] = '{6'd1, 6'd2, 6'd3, 6'd4};
    for (int k = 0; k < 4; k++) begin
      set_req(chs[k], 1'b1, pids[k]);
      @(negedge aclk);
      n_checks++;
      if (bus0.s_ready !== (4'b0001 << chs[k])) begin
        n_errors++; $display("FAIL fill[%0d]: got %b want %b", k, bus0.s_ready, 4'b0001 << chs[k]);
      end
      sb.push_back(mk(chs[k], pids[k]));
      tick();
      clr0();
    end
    set_req(2, 1'b1, 6'd5);
    @(negedge aclk);
    n_checks++;
    if ({bus0.s_ready, bus0.m_host_valid, bus0.m_card_valid} !== 6'd0) begin
      n_errors++; $display("FAIL full_block: got sr=%b hv=%b cv=%b want 0", bus0.s_ready, bus0.m_host_valid, bus0.m_card_valid);
    end
    tick();
    set_req(3, 1'b0, 6'd6);
    @(negedge aclk);
    n_checks++;
    if (bus0.s_ready !== 4'b1000) begin n_errors++; $display("FAIL full_nonctl: got %b want 1000", bus0.s_ready); end
    tick();
    clr0();
    do_completion("full_pop");
    set_req(1, 1'b1, 6'd6);
    bus0.card_done = 1'b1;
    @(negedge aclk);
    n_checks++;
    if (bus0.s_ready !== 4'b0010) begin n_errors++; $display("FAIL simul_issue: got %b want 0010", bus0.s_ready); end
    sb.push_back(mk(1, 6'd6));
    tick();
    clr0();
    @(negedge aclk);
    e = sb.pop_front();
    n_checks++;
    if ({bus0.rsp_done, bus0.rsp_pid, crd0(1)} !== {4'b0001 << e.ch, e.pid, 2'd1}) begin
      n_errors++; $display("FAIL simul_credit: got rsp=%b pid=%0d credit=%0d want %b %0d 1",
                           bus0.rsp_done, bus0.rsp_pid, crd0(1), 4'b0001 << e.ch, e.pid);
    end
    tick();
    set_req(3, 1'b1, 6'd8);
    @(negedge aclk);
    n_checks++;
    if (bus0.s_ready !== 4'b1000) begin n_errors++; $display("FAIL simul_count: got %b want 1000", bus0.s_ready); end
    sb.push_back(mk(3, 6'd8));
    tick();
    set_req(3, 1'b1, 6'd9);
    bus0.card_done = 1'b1;
    @(negedge aclk);
    n_checks++;
    if (bus0.s_ready !== 4'b0000) begin n_errors++; $display("FAIL full_pop_block: got %b want 0000", bus0.s_ready); end
    tick();
    clr0();
    @(negedge aclk);
    e = sb.pop_front();
    n_checks++;
    if ({bus0.rsp_done, bus0.rsp_pid} !== {4'b0001 << e.ch, e.pid}) begin
      n_errors++; $display("FAIL full_pop_rsp: got rsp=%b pid=%0d want %b %0d", bus0.rsp_done, bus0.rsp_pid, 4'b0001 << e.ch, e.pid);
    end
    tick();
    do_completion("full_drain0");
    do_completion("full_drain1");
    do_completion("full_drain2");
    @(negedge aclk);
    n_checks++;
    if (bus0.credit_cnt !== 8'h00) begin n_errors++; $display("FAIL full_credit_zero: got %h want 00", bus0.credit_cnt); end
    tick();
  endtask

  task automatic test_spurious_reset();
    @(negedge aclk);
    n_checks++;
    if (bus0.err_spurious !== 1'b0) begin n_errors++; $display("FAIL spur_pre: got %b want 0", bus0.err_spurious); end
    tick();
    bus0.card_done = 1'b1;
    tick();
    bus0.card_done = 1'b0;
    @(negedge aclk);
    n_checks++;
    if ({bus0.err_spurious, bus0.rsp_done} !== 5'b10000) begin
      n_errors++; $display("FAIL spur_set: got err=%b rsp=%b want 1 0000", bus0.err_spurious, bus0.rsp_done);
    end
    tick();
    for (int c = 0; c < 3; c++) begin
      set_req(c, 1'b1, 6'(40 + c));
      @(negedge aclk);
      n_checks++;
      if (bus0.s_ready !== (4'b0001 << c)) begin n_errors++; $display("FAIL rst_fill[%0d]: got %b want %b", c, bus0.s_ready, 4'b0001 << c); end
      sb.push_back(mk(c, 6'(40 + c)));
      tick();
      clr0();
    end
    aresetn = 1'b0;
    tick();
    aresetn = 1'b1;
    sb.delete();
    @(negedge aclk);
    n_checks++;
    if ({bus0.credit_cnt, bus0.err_spurious, bus0.rsp_done} !== 13'd0) begin
      n_errors++; $display("FAIL rst_clear: got credit=%h err=%b rsp=%b want zeros", bus0.credit_cnt, bus0.err_spurious, bus0.rsp_done);
    end
    tick();
    for (int c = 0; c < 4; c++) set_req(c, 1'b0, 6'd50);
    @(negedge aclk);
    n_checks++;
    if (bus0.s_ready !== 4'b0001) begin n_errors++; $display("FAIL rst_restart: got %b want 0001", bus0.s_ready); end
    tick();
    clr0();
    bus0.card_done = 1'b1;
    tick();
    bus0.card_done = 1'b0;
    @(negedge aclk);
    n_checks++;
    if (bus0.err_spurious !== 1'b1) begin n_errors++; $display("FAIL rst_stale_done: got %b want 1", bus0.err_spurious); end
    tick();
  endtask

  task automatic test_done_sel();
    exp_t e;
    e = mk(0, 6'd33);
    bus1.s_valid[0] = 1'b1;  bus1.s_ctl[0] = 1'b1;  bus1.s_pid[5:0] = e.pid;
    bus1.s_dest[3:0] = e.dest;  bus1.s_stream[0] = e.stream;  bus1.s_host[0] = e.host;
    @(negedge aclk);
    n_checks++;
    if (bus1.s_ready !== 4'b0001) begin n_errors++; $display("FAIL dsel_issue: got %b want 0001", bus1.s_ready); end
    sb.push_back(e);
    tick();
    bus1.s_valid = 4'b0000;
    bus1.card_done = 1'b1;
    tick();
    bus1.card_done = 1'b0;
    @(negedge aclk);
    n_checks++;
    if ({bus1.rsp_done, bus1.err_spurious, bus1.credit_cnt[1:0]} !== {4'b0000, 1'b0, 2'd1}) begin
      n_errors++; $display("FAIL dsel_card_ignored: got rsp=%b err=%b credit=%0d want 0000 0 1", bus1.rsp_done, bus1.err_spurious, bus1.credit_cnt[1:0]);
    end
    tick();
    bus1.host_done = 1'b1;
    tick();
    bus1.host_done = 1'b0;
    @(negedge aclk);
    e = sb.pop_front();
    n_checks++;
    if ({bus1.rsp_done, bus1.rsp_pid, bus1.rsp_dest, bus1.credit_cnt[1:0]} !== {4'b0001, e.pid, e.dest, 2'd0}) begin
      n_errors++; $display("FAIL dsel_host_done: got rsp=%b pid=%0d dest=%h credit=%0d want 0001 %0d %h 0",
                           bus1.rsp_done, bus1.rsp_pid, bus1.rsp_dest, bus1.credit_cnt[1:0], e.pid, e.dest);
    end
    tick();
    bus1.host_done = 1'b1;
    tick();
    bus1.host_done = 1'b0;
    @(negedge aclk);
    n_checks++;
    if (bus1.err_spurious !== 1'b1) begin n_errors++; $display("FAIL dsel_spurious: got %b want 1", bus1.err_spurious); end
    tick();
  endtask

  initial begin
    bus0.s_valid = 4'b0000;  bus0.s_ctl = 4'b0000;  bus0.s_stream = 4'b0000;  bus0.s_host = 4'b0000;
    bus0.s_paddr_host = '0;  bus0.s_paddr_card = '0;  bus0.s_len = '0;  bus0.s_pid = '0;  bus0.s_dest = '0;
    bus0.m_host_ready = 1'b1;  bus0.m_card_ready = 1'b1;  bus0.host_done = 1'b0;  bus0.card_done = 1'b0;
    bus1.s_valid = 4'b0000;  bus1.s_ctl = 4'b0000;  bus1.s_stream = 4'b0000;  bus1.s_host = 4'b0000;
    bus1.s_paddr_host = '0;  bus1.s_paddr_card = '0;  bus1.s_len = '0;  bus1.s_pid = '0;  bus1.s_dest = '0;
    bus1.m_host_ready = 1'b1;  bus1.m_card_ready = 1'b1;  bus1.host_done = 1'b0;  bus1.card_done = 1'b0;
    test_reset();
    test_fairness();
    test_backpressure();
    test_credits();
    test_ordering();
    test_full_and_simul();
    test_spurious_reset();
    test_done_sel();
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule
